// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Segment patterns are active-high, bit order g..a.
package seg_pkg;

   localparam int NUM_DIGITS = 4;

   // Index n holds the pattern for hex digit n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [3:0] SEL_OFF = 4'hF;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } seg_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern (g..a).
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg_mux_scan.sv
// Four-digit common-anode display scanner with inter-slot blanking and tear-free loads.
// Optional leading-zero suppression is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_mux_scan
   import seg_pkg::*;
#(
   parameter int CLK_HZ       = 100000000,
   parameter int DIGIT_HZ     = 1000,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits_i,
   input  logic [3:0]  dp_i,
   input  logic        load_i,
   input  logic        en_i,
   output logic [3:0]  io_sel,
   output logic [7:0]  io_seg,
   output logic        frame_o
);

   localparam int TICKS = CLK_HZ / DIGIT_HZ;
   localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   seg_state_e       state_q, state_d;
   logic [15:0]      pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
   logic [3:0]       pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [3:0]       sel_q, sel_d;
   logic [7:0]       seg_q, seg_d;
   logic             frame_q, frame_d;

   logic             wrap;
   logic             frame_start;
   logic [3:0]       cur_nib;
   logic [6:0]       dec_pat;
   logic [6:0]       seg_pat;

   assign wrap        = (cnt_q == CNT_LAST);
   assign frame_start = wrap && (idx_q == 2'd3);
   assign cur_nib     = act_dig_q[idx_q*4 +: 4];

   seg_hex_decode u_dec (
      .nib_i (cur_nib),
      .seg_o (dec_pat)
   );

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // lz_mask[k]: digit k and every digit above it are zero; digit 0 never blanks.
   logic [NUM_DIGITS-1:0] lz_mask;
   assign lz_mask[NUM_DIGITS-1] = (act_dig_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
   assign lz_mask[0]            = 1'b0;
   generate
      for (genvar gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_lz
         assign lz_mask[gi] = lz_mask[gi+1] && (act_dig_q[gi*4 +: 4] == 4'h0);
      end
   endgenerate
   assign seg_pat = lz_mask[idx_q] ? 7'h00 : dec_pat;
`else
   assign seg_pat = dec_pat;
`endif

   always_comb begin
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      idx_d      = wrap ? idx_q + 2'd1 : idx_q;
      pend_dig_d = load_i ? digits_i : pend_dig_q;
      pend_dp_d  = load_i ? dp_i : pend_dp_q;
      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      frame_d    = frame_start;
      // A load landing on either frame-boundary cycle bypasses pending straight to active.
      if (frame_start) begin
         act_dig_d = load_i ? digits_i : pend_dig_q;
         act_dp_d  = load_i ? dp_i : pend_dp_q;
      end else if (frame_q && load_i) begin
         act_dig_d = digits_i;
         act_dp_d  = dp_i;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BLANK:   if (cnt_d >= BLANK_END) state_d = ON;
         ON:      if (wrap) state_d = BLANK;
         default: state_d = BLANK;
      endcase
   end

   always_comb begin
      sel_d = SEL_OFF;
      seg_d = SEG_OFF;
      if (en_i && (state_q == ON)) begin
         sel_d = ~(4'b0001 << idx_q);
         seg_d = ~{act_dp_q[idx_q], seg_pat};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         state_q    <= BLANK;
         pend_dig_q <= 16'h0000;
         pend_dp_q  <= 4'h0;
         act_dig_q  <= 16'h0000;
         act_dp_q   <= 4'h0;
         sel_q      <= SEL_OFF;
         seg_q      <= SEG_OFF;
         frame_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         state_q    <= state_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         frame_q    <= frame_d;
      end
   end

   assign io_sel  = sel_q;
   assign io_seg  = seg_q;
   assign frame_o = frame_q;

endmodule

// File: doc/seg_mux_scan.md
Name: seg_mux_scan

Overview:
- Time-multiplexed driver for the 4-digit common-anode seven-segment display on io_sel/io_seg.
- Takes a 16-bit packed hex/BCD value plus decimal points and rotates through the digits at a fixed per-digit rate.
- Inserts a blanking gap between digit slots to suppress ghosting.
- Sits between user logic, such as DIP-switch or counter values, and the top-level display pins; replaces the single-digit static drive.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- DIGIT_HZ, 1000, per-digit slot rate. TICKS = CLK_HZ/DIGIT_HZ cycles per slot; must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 64, cycles at the start of each slot with all digits off.

Ports:
- clk  input  1  100 MHz system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- digits_i  input  16  nibble k = digit k; digit 0 is rightmost.
- dp_i  input  4  decimal point per digit, 1 = lit.
- load_i  input  1  one-cycle strobe; captures digits_i/dp_i.
- en_i  input  1  1 = display on, 0 = all blank.
- io_sel  output  4  digit enables, active-low.
- io_seg  output  8  segments active-low; [6:0] = g..a, [7] = dp.
- frame_o  output  1  one-cycle pulse at the start of slot 0.

Behaviour:
- Reset values:
  - io_sel = 4'hF, io_seg = 8'hFF, frame_o = 0.
  - slot counter = 0, digit index = 0, pending/active registers = 0.
  - FSM in BLANK.
- Slot counter:
  - Counts 0..TICKS-1 and wraps to 0.
  - On wrap, digit index increments 0→1→2→3→0.
- FSM, evaluated per slot:
  - BLANK while counter < BLANK_CYCLES.
  - ON for the remaining cycles of the slot.
  - ON→BLANK at every counter wrap.
- Output timing: all outputs are registered, one cycle after the counter/state that selects them.
  - BLANK: io_sel = 4'hF, io_seg = 8'hFF.
  - ON: io_sel = ~(1<<idx), io_seg = ~{dp_active[idx], hex7(active[idx])}.
- hex7 decodes 0-F to standard patterns. Expected io_seg values with dp off: 0 = 8'hC0, 1 = 8'hF9, 8 = 8'h80, A = 8'h88, F = 8'h8E.
- Load handling:
  - load_i writes digits_i/dp_i into the pending register.
  - Pending transfers to active only at frame start (counter wrap into idx 0), so there is no mid-frame tearing.
  - load_i coincident with the frame-start cycle: the new input values go directly to active for that frame.
  - Multiple loads within one frame: the last one wins.
- frame_o is high for exactly the one cycle in which idx becomes 0 and active is updated.
- en_i = 0:
  - Outputs forced to BLANK values on the next cycle.
  - Counter, index, frame_o and loads continue unaffected.
  - Re-enable resumes mid-slot in the correct phase.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); scanning restarts at idx 0, BLANK, on the first clock after deassertion.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: during ON, digit k (k = 3..1) shows segments [6:0] off when active[k] == 0 and all higher digits are also 0. Digit 0 is always shown. The dp bit is still driven from dp_active.
- Undefined: all four digits are always decoded, with no blanking logic synthesized.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS = 4.
  - 7-bit segment constants for 0-F (active-high g..a).
  - SEG_OFF = 8'hFF, SEL_OFF = 4'hF.
  - FSM state typedef {BLANK, ON}.
- Sub-module seg_hex_decode: combinational 4-bit → 7-bit active-high pattern from the seg_pkg table; instantiated once on the muxed nibble.

Test Plan (sim with CLK_HZ=800, DIGIT_HZ=100 → TICKS=8, BLANK_CYCLES=2):
- Reset: hold rst_n=0 → io_sel=4'hF, io_seg=8'hFF, frame_o=0. Release → first ON cycle shows idx 0.
- Display 0x18A0: load_i pulse with digits_i=16'h18A0, dp_i=0, en_i=1 → after the next frame_o, the slot sequence is:
  - sel 4'hE / seg 8'hC0
  - 4'hD / 8'h88
  - 4'hB / 8'h80
  - 4'h7 / 8'hF9
  - Each slot is preceded by exactly 2 cycles of 4'hF/8'hFF; period 32 cycles between frame_o pulses.
- Tear-free load: load 16'h1111, then mid-frame (idx 2) load 16'h2222 → digits 2-3 of the current frame still show 8'hF9; next frame all show 8'hA4.
- Coincident load and multiple loads: load on the frame_o cycle → that frame uses the new value. Two loads in one frame → only the last is displayed.
- en_i and dp: en_i=0 for 10 cycles mid-slot → all-off outputs next cycle, frame_o period unchanged. dp_i=4'b0001 → digit 0 io_seg[7]=0.
- Feature on (SEG_LEADING_ZERO_BLANK_EN): digits 16'h0050 → digits 3 and 2 show seg 8'hFF with sel active, digit 1 = 8'h92, digit 0 = 8'hC0. Value 0 → only digit 0 lit (8'hC0).
